// File: rtl/rv32i_rob_multiway.sv
// Multi-way RV32I reorder buffer with in-order group retire.
// Exception handling is enabled by defining RV32I_ROB_EXCEPT_EN.
module rv32i_rob_multiway #(
  parameter int ROB_DEPTH = 16,
  parameter int DISP_W    = 2,
  parameter int RET_W     = 2,
  parameter int WB_PORTS  = 2,
  parameter int PRF_BW    = 6,
  parameter int ARF_BW    = 5,
  parameter int IDX_BW    = $clog2(ROB_DEPTH)
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [DISP_W-1:0]          i_disp_vld,
  input  logic [DISP_W-1:0]          i_disp_dst_vld,
  input  logic [DISP_W*PRF_BW-1:0]   i_disp_phys_tag,
  input  logic [DISP_W*ARF_BW-1:0]   i_disp_arch_idx,
  output logic                       o_disp_rdy,
  output logic [DISP_W*IDX_BW-1:0]   o_rob_entry_idx,
  input  logic [WB_PORTS-1:0]        i_wb_vld,
  input  logic [WB_PORTS*IDX_BW-1:0] i_wb_idx,
  input  logic [WB_PORTS-1:0]        i_wb_except,
  input  logic                       i_except_handler_done,
  output logic [IDX_BW:0]            o_free_cnt,
  output logic                       o_empty,
  output logic [RET_W-1:0]           o_ret_vld,
  output logic [RET_W-1:0]           o_ret_dst_vld,
  output logic [RET_W*PRF_BW-1:0]    o_ret_phys_tag,
  output logic [RET_W*ARF_BW-1:0]    o_ret_arch_idx,
  output logic                       o_except_vld,
  output logic [IDX_BW-1:0]          o_except_idx,
  output logic                       o_flush
);

  localparam logic [IDX_BW:0] DEPTH_C = (IDX_BW+1)'(ROB_DEPTH);
  localparam logic [IDX_BW:0] DISP_C  = (IDX_BW+1)'(DISP_W);
  localparam logic [IDX_BW:0] ONE_C   = (IDX_BW+1)'(1);

  typedef enum logic {RUN, HALT} st_e;

  st_e                  st_q, st_d;
  logic [IDX_BW:0]      rd_q, rd_d, wr_q, wr_d, n_disp, n_ret;
  logic [ROB_DEPTH-1:0] vld_q, vld_d, done_q, done_d, exc_q, exc_d;
  logic [ROB_DEPTH-1:0] dvld_q;
  logic [PRF_BW-1:0]    tag_q  [ROB_DEPTH];
  logic [ARF_BW-1:0]    arch_q [ROB_DEPTH];
  logic [DISP_W-1:0]    disp_we;
  logic [IDX_BW-1:0]    alloc  [DISP_W];
  logic [RET_W-1:0]     ret_we;
  logic [IDX_BW-1:0]    ret_idx [RET_W];
  logic                 hit_exc;
  logic [IDX_BW-1:0]    exc_idx;
  logic [WB_PORTS-1:0]  wb_exc;
  logic                 hdone;
  logic [RET_W-1:0]     rv_q, rdv_q;
  logic [RET_W*PRF_BW-1:0] rtag_q;
  logic [RET_W*ARF_BW-1:0] rarch_q;

  assign o_free_cnt = DEPTH_C - (wr_q - rd_q);
  assign o_empty    = (rd_q == wr_q);
  assign o_disp_rdy = (st_q == RUN) && (o_free_cnt >= DISP_C);
  assign o_ret_vld      = rv_q;
  assign o_ret_dst_vld  = rdv_q;
  assign o_ret_phys_tag = rtag_q;
  assign o_ret_arch_idx = rarch_q;

  // Dispatch: accept the contiguous run of requests starting at lane 0.
  always_comb begin
    logic run;
    run    = 1'b1;
    n_disp = '0;
    for (int k = 0; k < DISP_W; k++) begin
      run        = run & i_disp_vld[k];
      disp_we[k] = run & o_disp_rdy;
      alloc[k]   = wr_q[IDX_BW-1:0] + IDX_BW'(k);
      o_rob_entry_idx[k*IDX_BW +: IDX_BW] = alloc[k];
      if (disp_we[k]) n_disp = n_disp + ONE_C;
    end
  end

  // Retire: longest chain of oldest done, non-excepting entries.
  always_comb begin
    logic chain;
    chain   = 1'b1;
    n_ret   = '0;
    hit_exc = 1'b0;
    exc_idx = '0;
    for (int k = 0; k < RET_W; k++) begin
      ret_idx[k] = rd_q[IDX_BW-1:0] + IDX_BW'(k);
      if (chain && vld_q[ret_idx[k]] && done_q[ret_idx[k]]
          && exc_q[ret_idx[k]]) begin
        hit_exc = 1'b1;
        exc_idx = ret_idx[k];
      end
      chain = chain & vld_q[ret_idx[k]] & done_q[ret_idx[k]]
            & ~exc_q[ret_idx[k]];
      ret_we[k] = chain;
      if (chain) n_ret = n_ret + ONE_C;
    end
  end

  // Next-state for pointers, entry flags and run/halt state.
  always_comb begin
    st_d   = st_q;
    rd_d   = rd_q + n_ret;
    wr_d   = wr_q + n_disp;
    vld_d  = vld_q;
    done_d = done_q;
    exc_d  = exc_q;
    if (st_q == RUN) begin
      for (int p = 0; p < WB_PORTS; p++) begin
        if (i_wb_vld[p] && vld_q[i_wb_idx[p*IDX_BW +: IDX_BW]]) begin
          done_d[i_wb_idx[p*IDX_BW +: IDX_BW]] = 1'b1;
          exc_d[i_wb_idx[p*IDX_BW +: IDX_BW]] =
            exc_d[i_wb_idx[p*IDX_BW +: IDX_BW]] | wb_exc[p];
        end
      end
    end
    for (int k = 0; k < RET_W; k++)
      if (ret_we[k]) vld_d[ret_idx[k]] = 1'b0;
    for (int k = 0; k < DISP_W; k++) begin
      if (disp_we[k]) begin
        vld_d[alloc[k]]  = 1'b1;
        done_d[alloc[k]] = 1'b0;
        exc_d[alloc[k]]  = 1'b0;
      end
    end
    if (hit_exc) begin
      st_d  = HALT;
      vld_d = '0;
      rd_d  = rd_q + n_ret + ONE_C;
      wr_d  = rd_q + n_ret + ONE_C;
    end else if (st_q == HALT && hdone) begin
      st_d = RUN;
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      st_q   <= RUN;
      rd_q   <= '0;
      wr_q   <= '0;
      vld_q  <= '0;
      done_q <= '0;
      exc_q  <= '0;
    end else begin
      st_q   <= st_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      vld_q  <= vld_d;
      done_q <= done_d;
      exc_q  <= exc_d;
    end
  end

  // Entry payload storage, written on accepted dispatch.
  always_ff @(posedge clk) begin
    for (int k = 0; k < DISP_W; k++) begin
      if (disp_we[k]) begin
        dvld_q[alloc[k]] <= i_disp_dst_vld[k];
        tag_q[alloc[k]]  <= i_disp_phys_tag[k*PRF_BW +: PRF_BW];
        arch_q[alloc[k]] <= i_disp_arch_idx[k*ARF_BW +: ARF_BW];
      end
    end
  end

  // Registered retire lanes; idle lanes drive zero.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rv_q    <= '0;
      rdv_q   <= '0;
      rtag_q  <= '0;
      rarch_q <= '0;
    end else begin
      rv_q <= ret_we;
      for (int k = 0; k < RET_W; k++) begin
        rdv_q[k] <= ret_we[k] & dvld_q[ret_idx[k]];
        rtag_q[k*PRF_BW +: PRF_BW] <=
          ret_we[k] ? tag_q[ret_idx[k]] : '0;
        rarch_q[k*ARF_BW +: ARF_BW] <=
          ret_we[k] ? arch_q[ret_idx[k]] : '0;
      end
    end
  end

`ifdef RV32I_ROB_EXCEPT_EN
  logic              exv_q, fl_q;
  logic [IDX_BW-1:0] exi_q;

  assign wb_exc       = i_wb_except;
  assign hdone        = i_except_handler_done;
  assign o_except_vld = exv_q;
  assign o_except_idx = exi_q;
  assign o_flush      = fl_q;

  // Exception report pulse, followed one cycle later by flush.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      exv_q <= 1'b0;
      exi_q <= '0;
      fl_q  <= 1'b0;
    end else begin
      exv_q <= hit_exc;
      exi_q <= hit_exc ? exc_idx : '0;
      fl_q  <= exv_q;
    end
  end
`else
  logic unused_exc;

  assign wb_exc       = '0;
  assign hdone        = 1'b0;
  assign o_except_vld = 1'b0;
  assign o_except_idx = '0;
  assign o_flush      = 1'b0;
  assign unused_exc   = ^{i_wb_except, i_except_handler_done,
                          exc_idx};
`endif

endmodule

// File: tb/tb_rv32i_rob_multiway.sv
// Directed scoreboard bench for rv32i_rob_multiway.
// Build with RV32I_ROB_EXCEPT_EN to cover the exception path.
module tb_rv32i_rob_multiway;

  localparam int D = 8;
  localparam int IW = 3;

  typedef struct packed {
    logic       dst;
    logic [5:0] tag;
    logic [4:0] arch;
  } ret_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic [1:0]    disp_vld, disp_dst;
  logic [11:0]   disp_tag;
  logic [9:0]    disp_arch;
  logic          disp_rdy;
  logic [5:0]    entry_idx;
  logic [1:0]    wb_vld, wb_exc;
  logic [5:0]    wb_idx;
  logic          hdone;
  logic [3:0]    free_cnt;
  logic          empty;
  logic [1:0]    ret_vld, ret_dst;
  logic [11:0]   ret_tag;
  logic [9:0]    ret_arch;
  logic          exc_vld, flush;
  logic [2:0]    exc_idx;

  int   checks = 0;
  int   errors = 0;
  int   tag_ctr = 1;
  ret_t sb[$];

  rv32i_rob_multiway #(
    .ROB_DEPTH(D), .DISP_W(2), .RET_W(2), .WB_PORTS(2),
    .PRF_BW(6), .ARF_BW(5)
  ) dut (
    .clk(clk), .rstn(rstn),
    .i_disp_vld(disp_vld), .i_disp_dst_vld(disp_dst),
    .i_disp_phys_tag(disp_tag), .i_disp_arch_idx(disp_arch),
    .o_disp_rdy(disp_rdy), .o_rob_entry_idx(entry_idx),
    .i_wb_vld(wb_vld), .i_wb_idx(wb_idx), .i_wb_except(wb_exc),
    .i_except_handler_done(hdone),
    .o_free_cnt(free_cnt), .o_empty(empty),
    .o_ret_vld(ret_vld), .o_ret_dst_vld(ret_dst),
    .o_ret_phys_tag(ret_tag), .o_ret_arch_idx(ret_arch),
    .o_except_vld(exc_vld), .o_except_idx(exc_idx),
    .o_flush(flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string t, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", t, got, exp);
    end
  endtask

  // Scoreboard: pop one expected record per retired lane.
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      for (int k = 0; k < 2; k++) begin
        if (ret_vld[k]) begin
          if (sb.size() == 0) begin
            chk("ret_unexpected", 32'(k), 32'hFF);
          end else begin
            ret_t e, g;
            e = sb.pop_front();
            g = '{ret_dst[k], ret_tag[k*6 +: 6], ret_arch[k*5 +: 5]};
            chk("ret_payload", 32'(g), 32'(e));
          end
        end
      end
    end
  end

  task automatic dispatch(input bit acc, input int idx0);
    for (int k = 0; k < 2; k++) begin
      disp_tag[k*6 +: 6]  = 6'(tag_ctr + k);
      disp_arch[k*5 +: 5] = 5'(tag_ctr + k + 10);
      disp_dst[k]         = 1'((tag_ctr + k) & 1);
    end
    disp_vld = 2'b11;
    #1;
    chk("disp_rdy", 32'(disp_rdy), 32'(acc));
    if (acc) begin
      for (int k = 0; k < 2; k++) begin
        chk("entry_idx", 32'(entry_idx[k*IW +: IW]),
            32'((idx0 + k) % D));
        sb.push_back('{1'((tag_ctr + k) & 1), 6'(tag_ctr + k),
                       5'(tag_ctr + k + 10)});
      end
      tag_ctr += 2;
    end
    @(negedge clk);
    disp_vld = 2'b00;
  endtask

  task automatic wb(input bit v0, input int i0, input bit e0,
                    input bit v1, input int i1, input bit e1);
    wb_vld = {v1, v0};
    wb_idx = {3'(i1), 3'(i0)};
    wb_exc = {e1, e0};
    @(negedge clk);
    wb_vld = 2'b00;
    wb_exc = 2'b00;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    disp_vld = '0; disp_dst = '0; disp_tag = '0; disp_arch = '0;
    wb_vld = '0; wb_idx = '0; wb_exc = '0; hdone = 1'b0;
    @(negedge clk);
    do_reset();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_free", 32'(free_cnt), 32'd8);
    chk("rst_rdy", 32'(disp_rdy), 32'd1);
    chk("rst_ret_vld", 32'(ret_vld), 32'd0);
    chk("rst_exc_vld", 32'(exc_vld), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);

    // Lane 0 idle: the whole group is ignored.
    disp_vld = 2'b10;
    @(negedge clk);
    disp_vld = 2'b00;
    chk("noncontig_free", 32'(free_cnt), 32'd8);

    // Fill: 4 x 2 lanes.
    dispatch(1'b1, 0);
    chk("free_6", 32'(free_cnt), 32'd6);
    dispatch(1'b1, 2);
    dispatch(1'b1, 4);
    dispatch(1'b1, 6);
    chk("full_free", 32'(free_cnt), 32'd0);
    chk("full_rdy", 32'(disp_rdy), 32'd0);
    dispatch(1'b0, 0);
    chk("full_hold", 32'(free_cnt), 32'd0);

    // Out-of-order write-back 3,1,0,2.
    wb(1, 3, 0, 0, 0, 0);
    chk("wb3_noret", 32'(ret_vld), 32'd0);
    wb(1, 1, 0, 0, 0, 0);
    chk("wb1_noret", 32'(ret_vld), 32'd0);
    wb(1, 0, 0, 0, 0, 0);
    chk("wb0_noret", 32'(ret_vld), 32'd0);
    wb(1, 2, 0, 0, 0, 0);
    chk("ret01_vld", 32'(ret_vld), 32'd3);
    chk("ret01_free", 32'(free_cnt), 32'd2);
    @(negedge clk);
    chk("ret23_vld", 32'(ret_vld), 32'd3);
    chk("ret23_free", 32'(free_cnt), 32'd4);
    @(negedge clk);
    chk("ret_idle", 32'(ret_vld), 32'd0);

    // Wrapped write pointer.
    dispatch(1'b1, 0);
    chk("wrap_free2", 32'(free_cnt), 32'd2);
    dispatch(1'b1, 2);
    chk("wrap_free0", 32'(free_cnt), 32'd0);

    // Drain, including a duplicate index on both ports.
    wb(1, 4, 0, 1, 5, 0);
    wb(1, 6, 0, 1, 7, 0);
    wb(1, 0, 0, 1, 0, 0);
    wb(1, 1, 0, 1, 2, 0);
    wb(1, 3, 0, 1, 3, 0);
    repeat (6) @(negedge clk);
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_free", 32'(free_cnt), 32'd8);
    chk("drain_sb", 32'(sb.size()), 32'd0);

    // Exception scenario from a fresh reset.
    do_reset();
    chk("rst2_empty", 32'(empty), 32'd1);
    dispatch(1'b1, 0);
    dispatch(1'b1, 2);
    wb(1, 0, 0, 1, 1, 1);
    wb(1, 2, 0, 1, 3, 0);
`ifdef RV32I_ROB_EXCEPT_EN
    chk("exc_ret_vld", 32'(ret_vld), 32'd1);
    chk("exc_vld", 32'(exc_vld), 32'd1);
    chk("exc_idx", 32'(exc_idx), 32'd1);
    chk("exc_flush0", 32'(flush), 32'd0);
    @(negedge clk);
    sb.delete();
    chk("flush_pulse", 32'(flush), 32'd1);
    chk("flush_exc_vld", 32'(exc_vld), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    chk("halt_rdy", 32'(disp_rdy), 32'd0);
    @(negedge clk);
    chk("flush_done", 32'(flush), 32'd0);
    chk("halt_rdy2", 32'(disp_rdy), 32'd0);
    hdone = 1'b1;
    @(negedge clk);
    hdone = 1'b0;
    chk("resume_rdy", 32'(disp_rdy), 32'd1);
    dispatch(1'b1, 2);
    wb(1, 2, 0, 1, 3, 0);
    repeat (3) @(negedge clk);
    chk("resume_empty", 32'(empty), 32'd1);
`else
    chk("noexc_ret01", 32'(ret_vld), 32'd3);
    chk("noexc_vld", 32'(exc_vld), 32'd0);
    @(negedge clk);
    chk("noexc_ret23", 32'(ret_vld), 32'd3);
    chk("noexc_flush", 32'(flush), 32'd0);
    @(negedge clk);
    chk("noexc_empty", 32'(empty), 32'd1);
    chk("noexc_free", 32'(free_cnt), 32'd8);
`endif
    chk("final_sb", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
